// File: rtl/regfile_pkg.sv
// Shared types and default sizing for regfile and its write-port arbiter.
package regfile_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_NUM_REGS   = 32;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic adv,
  output logic gnt0,
  output logic gnt1
);

  req_id_e last_grant_q, last_grant_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0_valid && (!req1_valid || last_grant_q == REQ1)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (adv) begin
      last_grant_d = gnt1 ? REQ1 : REQ0;
    end
  end

  // Reset to REQ1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the regfile write port: sweeps all registers to INIT_VALUE after reset,
// then shares the port round-robin between two valid/ready writeback requesters.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit ZERO_REG_EN = 1'b1,
  localparam int unsigned AW = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [AW-1:0]         req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [AW-1:0]         req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_rd,
  output logic [DATA_WIDTH-1:0] rf_d,
  output logic                  init_done,
  output logic                  err
);

  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_REGS - 1);
  localparam logic [AW:0]   ADDR_LIMIT = (AW + 1)'(NUM_REGS);

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic                    rf_we_q, rf_we_d;
  logic [AW-1:0]           rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0]   rf_d_q, rf_d_d;
  logic                    init_done_q, init_done_d;
  logic                    err_q, err_d;

  logic                    gnt0, gnt1, xfer;
  logic [AW-1:0]           win_addr;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    out_of_range, zero_hit;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == S_RUN),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .adv        (xfer),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_d_d       = rf_d_q;
    init_done_d  = init_done_q;
    err_d        = 1'b0;
    win_addr     = gnt1 ? req1_addr : req0_addr;
    win_data     = gnt1 ? req1_data : req0_data;
    out_of_range = ({1'b0, win_addr} >= ADDR_LIMIT);
    zero_hit     = ZERO_REG_EN && (win_addr == '0);
    case (state_q)
      S_INIT: begin
        rf_we_d = 1'b1;
        rf_rd_d = cnt_q;
        rf_d_d  = INIT_VALUE;
        if (cnt_q == LAST_IDX) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Suppressed writes (reg 0, out of range) are still accepted and registered.
        if (xfer) begin
          rf_rd_d = win_addr;
          rf_d_d  = win_data;
          rf_we_d = !out_of_range && !zero_hit;
          err_d   = out_of_range;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_d_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_d_q      <= rf_d_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_d      = rf_d_q;
  assign init_done = init_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter against a
// request-queue / register-array reference model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned NR   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NR24 = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          r0v = 1'b0, r1v = 1'b0;
  logic [AW-1:0] r0a = '0, r1a = '0;
  logic [DW-1:0] r0d = '0, r1d = '0;
  logic          r0rdy, r1rdy, rf_we, init_done, err;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_d;

  logic          s0v = 1'b0, s1v = 1'b0;
  logic [AW-1:0] s0a = '0, s1a = '0;
  logic [DW-1:0] s0d = '0, s1d = '0;
  logic          s0rdy, s1rdy, t_we, t_done, t_err;
  logic [AW-1:0] t_rd;
  logic [DW-1:0] t_d;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(r0rdy),
    .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(r1rdy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_d(rf_d), .init_done(init_done), .err(err)
  );

  regfile_write_arbiter #(.DATA_WIDTH(DW), .NUM_REGS(NR24)) dut24 (
    .clk(clk), .rst(rst),
    .req0_valid(s0v), .req0_addr(s0a), .req0_data(s0d), .req0_ready(s0rdy),
    .req1_valid(s1v), .req1_addr(s1a), .req1_data(s1d), .req1_ready(s1rdy),
    .rf_we(t_we), .rf_rd(t_rd), .rf_d(t_d), .init_done(t_done), .err(t_err)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  req_t          q0[$], q1[$];
  logic [AW-1:0] log_rd[$];
  int            last_win;
  logic          exp_we;
  logic [AW-1:0] exp_rd;
  logic [DW-1:0] exp_d;
  logic [DW-1:0] mem_m[NR];
  logic [DW-1:0] obs[NR];

  // One clock edge; the regfile commits whatever the write port showed before it.
  task automatic commit_edge();
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    we = rf_we; a = rf_rd; d = rf_d;
    @(posedge clk);
    #1;
    if (we === 1'b1) obs[a] = d;
  endtask

  task automatic step();
    int   win;
    req_t w;
    #1;
    win = -1;
    if (r0v && r1v) win = (last_win == 0) ? 1 : 0;
    else if (r0v)   win = 0;
    else if (r1v)   win = 1;
    check("ready0", r0rdy, win == 0);
    check("ready1", r1rdy, win == 1);
    commit_edge();
    if (win >= 0) begin
      w = (win == 0) ? {r0a, r0d} : {r1a, r1d};
      exp_rd   = w.a;
      exp_d    = w.d;
      exp_we   = (w.a != 0);
      last_win = win;
      if (exp_we) mem_m[w.a] = w.d;
      if (win == 0) begin r0v = 1'b0; void'(q0.pop_front()); end
      else          begin r1v = 1'b0; void'(q1.pop_front()); end
    end else begin
      exp_we = 1'b0;
    end
    check("rf_we", rf_we, exp_we);
    check("rf_rd", rf_rd, exp_rd);
    check("rf_d", rf_d, exp_d);
    check("err", err, 0);
    check("init_done", init_done, 1);
    if (rf_we) log_rd.push_back(rf_rd);
  endtask

  task automatic run_queues(input int unsigned budget, input int unsigned pct,
                            output int unsigned n);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || r0v || r1v) && n < budget) begin
      if (!r0v && q0.size() != 0 && $urandom_range(99) < pct) begin
        r0v = 1'b1; r0a = q0[0].a; r0d = q0[0].d;
      end
      if (!r1v && q1.size() != 0 && $urandom_range(99) < pct) begin
        r1v = 1'b1; r1a = q1[0].a; r1d = q1[0].d;
      end
      step();
      n++;
    end
    check("drain_budget", n < budget, 1);
  endtask

  task automatic reset_sweep(input bit hold_valids, input int abort_at);
    rst = 1'b1;
    r0v = hold_valids; r1v = hold_valids; r0a = 5'd3; r1a = 5'd4;
    s0v = 1'b0; s1v = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check("rst_we", rf_we, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_d", rf_d, 0);
    check("rst_done", init_done, 0);
    check("rst_err", err, 0);
    check("rst_rdy0", r0rdy, 0);
    check("rst_rdy1", r1rdy, 0);
    check("rst_t_done", t_done, 0);
    commit_edge();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(NR); k++) begin
      check("init_rdy0", r0rdy, 0);
      check("init_rdy1", r1rdy, 0);
      commit_edge();
      check("sweep_we", rf_we, 1);
      check("sweep_rd", rf_rd, k);
      check("sweep_d", rf_d, 0);
      check("sweep_done", init_done, k == int'(NR) - 1);
      check("sw24_we", t_we, k < int'(NR24));
      check("sw24_rd", t_rd, (k < int'(NR24)) ? k : int'(NR24) - 1);
      check("sw24_done", t_done, k >= int'(NR24) - 1);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_we", rf_we, 0);
        check("abort_rd", rf_rd, 0);
        check("abort_done", init_done, 0);
        return;
      end
    end
    r0v = 1'b0; r1v = 1'b0;
    last_win = 1; exp_we = 1'b0; exp_rd = AW'(NR - 1); exp_d = '0;
    for (int unsigned i = 0; i < NR; i++) mem_m[i] = '0;
  endtask

  task automatic compare_regfile(input string tag);
    commit_edge();
    for (int unsigned i = 0; i < NR; i++)
      check($sformatf("%s_r%0d", tag, i), obs[i], mem_m[i]);
  endtask

  logic [AW-1:0] alt_exp[6];
  int unsigned   n;
  logic [DW-1:0] prev7;

  initial begin
    alt_exp = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    reset_sweep(1'b1, -1);

    // Both requesters busy: strict alternation, req0 first after reset.
    log_rd.delete();
    for (int unsigned i = 0; i < 3; i++) begin
      q0.push_back(req_t'{a: AW'(1 + i), d: DW'(32'h100 + i)});
      q1.push_back(req_t'{a: AW'(9 + i), d: DW'(32'h900 + i)});
    end
    run_queues(50, 100, n);
    check("alt_cycles", n, 6);
    check("alt_count", log_rd.size(), 6);
    for (int unsigned i = 0; i < 6 && i < log_rd.size(); i++)
      check($sformatf("alt_rd%0d", i), log_rd[i], alt_exp[i]);

    log_rd.delete();
    q0.push_back(req_t'{a: 5'd5, d: 32'hDEADBEEF});
    run_queues(20, 100, n);
    check("w5_count", log_rd.size(), 1);
    commit_edge();
    check("w5_commit", obs[5], 32'hDEADBEEF);

    log_rd.delete();
    for (int unsigned i = 4; i < 8; i++) q1.push_back(req_t'{a: AW'(i), d: DW'($urandom)});
    run_queues(20, 100, n);
    check("r1_only_cycles", n, 4);
    check("r1_only_count", log_rd.size(), 4);
    for (int unsigned i = 0; i < 4 && i < log_rd.size(); i++)
      check($sformatf("r1_only_rd%0d", i), log_rd[i], 4 + i);

    log_rd.delete();
    q0.push_back(req_t'{a: 5'd0, d: 32'h1234});
    run_queues(20, 100, n);
    check("zero_count", log_rd.size(), 0);
    commit_edge();
    check("zero_commit", obs[0], 0);

    // NUM_REGS=24 instance: out-of-range address is accepted, dropped, flagged.
    s0v = 1'b1; s0a = 5'd30; s0d = 32'h0BAD;
    #1;
    check("oor_ready", s0rdy, 1);
    check("oor_ready1", s1rdy, 0);
    commit_edge();
    check("oor_we", t_we, 0);
    check("oor_err", t_err, 1);
    s0v = 1'b0;
    commit_edge();
    check("oor_err_pulse", t_err, 0);
    s0v = 1'b1; s0a = 5'd23; s0d = 32'h77;
    #1;
    check("top_ready", s0rdy, 1);
    commit_edge();
    check("top_we", t_we, 1);
    check("top_rd", t_rd, 23);
    check("top_d", t_d, 32'h77);
    check("top_err", t_err, 0);
    s0v = 1'b0;

    for (int unsigned i = 0; i < 40; i++) begin
      q0.push_back(req_t'{a: AW'($urandom_range(NR - 1)), d: DW'($urandom)});
      q1.push_back(req_t'{a: AW'($urandom_range(NR - 1)), d: DW'($urandom)});
    end
    run_queues(2000, 60, n);
    compare_regfile("rand1");

    reset_sweep(1'b0, 10);
    reset_sweep(1'b0, -1);

    prev7 = mem_m[7];
    q1.push_back(req_t'{a: 5'd7, d: 32'hAAAA5555});
    r1v = 1'b1; r1a = 5'd7; r1d = 32'hAAAA5555;
    step();
    rst = 1'b1;
    #1;
    check("midxfer_we", rf_we, 0);
    check("midxfer_done", init_done, 0);
    check("midxfer_rdy1", r1rdy, 0);
    commit_edge();
    check("midxfer_discard", obs[7], prev7);
    reset_sweep(1'b0, -1);

    for (int unsigned i = 0; i < 20; i++) begin
      q0.push_back(req_t'{a: AW'($urandom_range(NR - 1)), d: DW'($urandom)});
      q1.push_back(req_t'{a: AW'($urandom_range(NR - 1)), d: DW'($urandom)});
    end
    run_queues(1000, 80, n);
    compare_regfile("rand2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
